// File: rtl/hall_pkg.sv
// Shared definitions for the Hall sensor conditioning path: legal codes,
// FSM states and neighbour lookups along the forward rotation sequence.
package hall_pkg;

    localparam logic [2:0] HALL_OFF = 3'b000;
    localparam logic [2:0] HALL_S1  = 3'b101;
    localparam logic [2:0] HALL_S2  = 3'b100;
    localparam logic [2:0] HALL_S3  = 3'b110;
    localparam logic [2:0] HALL_S4  = 3'b010;
    localparam logic [2:0] HALL_S5  = 3'b011;
    localparam logic [2:0] HALL_S6  = 3'b001;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } hall_state_e;

    // Forward neighbour; HALL_OFF for 000/111 so callers can test legality.
    function automatic logic [2:0] hall_next(input logic [2:0] code);
        logic [2:0] nxt_s;
        case (code)
            HALL_S1: nxt_s = HALL_S2;
            HALL_S2: nxt_s = HALL_S3;
            HALL_S3: nxt_s = HALL_S4;
            HALL_S4: nxt_s = HALL_S5;
            HALL_S5: nxt_s = HALL_S6;
            HALL_S6: nxt_s = HALL_S1;
            default: nxt_s = HALL_OFF;
        endcase
        return nxt_s;
    endfunction

    function automatic logic [2:0] hall_prev(input logic [2:0] code);
        logic [2:0] prv_s;
        case (code)
            HALL_S1: prv_s = HALL_S6;
            HALL_S2: prv_s = HALL_S1;
            HALL_S3: prv_s = HALL_S2;
            HALL_S4: prv_s = HALL_S3;
            HALL_S5: prv_s = HALL_S4;
            HALL_S6: prv_s = HALL_S5;
            default: prv_s = HALL_OFF;
        endcase
        return prv_s;
    endfunction

    function automatic logic hall_legal(input logic [2:0] code);
        return (hall_next(code) != HALL_OFF);
    endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Synchronises the raw Hall bits and accepts a new code only after it has
// been stable for FILTER_CYCLES synchronised samples.
module hall_glitch_filter
    import hall_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hall_raw,
    input  logic       restart,
    output logic [2:0] acc,
    output logic [2:0] code,
    output logic       edge_evt
);

    localparam int              CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0][2:0] sync_r;
    logic [2:0]                  cand_r;
    logic [2:0]                  acc_r;
    logic [CNT_W-1:0]            cnt_r;

    logic [2:0]                  sync_code_s;
    logic [2:0]                  cand_nxt_s;
    logic [CNT_W-1:0]            cnt_nxt_s;
    logic                        accept_s;

    // Synchroniser shift chain, oldest sample in the top slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{3'b000}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], hall_raw};
        end
    end

    // Next candidate/count; acceptance is decided on the value the counter is about to take.
    always_comb begin
        sync_code_s = sync_r[SYNC_STAGES-1];
        cand_nxt_s  = cand_r;
        cnt_nxt_s   = cnt_r;
        if (sync_code_s != cand_r) begin
            cand_nxt_s = sync_code_s;
            cnt_nxt_s  = CNT_ONE;
        end else if ((cand_r != acc_r) && (cnt_r != CNT_FULL)) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
        accept_s = (cand_nxt_s != acc_r) && (cnt_nxt_s == CNT_FULL);
    end

    // Candidate, counter and accepted-code registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r <= 3'b000;
            cnt_r  <= {CNT_W{1'b0}};
            acc_r  <= 3'b000;
        end else if (restart) begin
            cand_r <= 3'b000;
            cnt_r  <= {CNT_W{1'b0}};
            acc_r  <= 3'b000;
        end else begin
            cand_r <= cand_nxt_s;
            cnt_r  <= cnt_nxt_s;
            if (accept_s) begin
                acc_r <= cand_nxt_s;
            end
        end
    end

    // The strobe and code are presented one cycle early so the consumer registers on the acceptance edge.
    assign acc      = acc_r;
    assign code     = cand_nxt_s;
    assign edge_evt = accept_s;

endmodule

// File: rtl/hall_sensor_conditioner.sv
// Hall sensor conditioner: glitch filter, legality/sequence FSM, direction
// detection and electrical-sector period / stall measurement.
module hall_sensor_conditioner
    import hall_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter int PERIOD_W      = 24,
    parameter int STALL_CYCLES  = 2**22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          hall_raw,
    input  logic                fault_clr,
    output logic [2:0]          hall_sensor,
    output logic                hall_valid,
    output logic                hall_fault,
    output logic                dir,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stall
);

    localparam logic [PERIOD_W-1:0] PER_ONE   = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] STALL_MAX = PERIOD_W'(STALL_CYCLES);

    logic [1:0]          rst_sync_r;
    logic                rst_int_n;

    hall_state_e         state_r;
    logic [2:0]          hall_sensor_r;
    logic                hall_valid_r;
    logic                hall_fault_r;
    logic                dir_r;
    logic [PERIOD_W-1:0] period_r;
    logic                period_valid_r;
    logic                stall_r;
    logic [PERIOD_W-1:0] per_cnt_r;
    logic                skip_r;

    logic [2:0]          acc_s;
    logic [2:0]          new_code_s;
    logic                edge_s;
    logic                legal_s;
    logic                fwd_s;
    logic                rev_s;
    logic                fault_accept_s;
    logic                restart_s;

    // Reset asserts asynchronously and releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_r[1];

    hall_glitch_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .hall_raw (hall_raw),
        .restart  (restart_s),
        .acc      (acc_s),
        .code     (new_code_s),
        .edge_evt (edge_s)
    );

    // Classify the code being accepted this cycle against the current one.
    always_comb begin
        legal_s = hall_legal(new_code_s);
        fwd_s   = legal_s && (new_code_s == hall_next(acc_s));
        rev_s   = legal_s && (new_code_s == hall_prev(acc_s));
        case (state_r)
            ST_RUN:  fault_accept_s = edge_s && !(fwd_s || rev_s);
            ST_INIT: fault_accept_s = edge_s && !legal_s;
            default: fault_accept_s = edge_s && !legal_s;
        endcase
        if ((state_r == ST_FAULT) && fault_clr && !fault_accept_s) begin
            restart_s = 1'b1;
        end else begin
            restart_s = 1'b0;
        end
    end

    // Sequencing FSM with period/stall measurement; all outputs registered here.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_r        <= ST_INIT;
            hall_sensor_r  <= HALL_OFF;
            hall_valid_r   <= 1'b0;
            hall_fault_r   <= 1'b0;
            dir_r          <= 1'b0;
            period_r       <= {PERIOD_W{1'b1}};
            period_valid_r <= 1'b0;
            stall_r        <= 1'b1;
            per_cnt_r      <= {PERIOD_W{1'b0}};
            skip_r         <= 1'b0;
        end else begin
            period_valid_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (edge_s && legal_s) begin
                        state_r       <= ST_RUN;
                        hall_sensor_r <= new_code_s;
                        hall_valid_r  <= 1'b1;
                        per_cnt_r     <= {PERIOD_W{1'b0}};
                        skip_r        <= 1'b1;
                    end else if (fault_accept_s) begin
                        state_r       <= ST_FAULT;
                        hall_sensor_r <= HALL_OFF;
                        hall_valid_r  <= 1'b0;
                        hall_fault_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fault_accept_s) begin
                        state_r       <= ST_FAULT;
                        hall_sensor_r <= HALL_OFF;
                        hall_valid_r  <= 1'b0;
                        hall_fault_r  <= 1'b1;
                    end else if (edge_s) begin
                        hall_sensor_r <= new_code_s;
                        dir_r         <= fwd_s;
                        per_cnt_r     <= {PERIOD_W{1'b0}};
                        // A stalled or freshly started interval is not a valid period.
                        if (stall_r || skip_r) begin
                            stall_r <= 1'b0;
                            skip_r  <= 1'b0;
                        end else begin
                            period_r       <= per_cnt_r + PER_ONE;
                            period_valid_r <= 1'b1;
                        end
                    end else if (per_cnt_r != STALL_MAX) begin
                        per_cnt_r <= per_cnt_r + PER_ONE;
                        if ((per_cnt_r + PER_ONE) == STALL_MAX) begin
                            stall_r <= 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (restart_s) begin
                        state_r      <= ST_INIT;
                        hall_fault_r <= 1'b0;
                        per_cnt_r    <= {PERIOD_W{1'b0}};
                    end
                end
                default: begin
                    state_r       <= ST_FAULT;
                    hall_sensor_r <= HALL_OFF;
                    hall_valid_r  <= 1'b0;
                    hall_fault_r  <= 1'b1;
                end
            endcase
        end
    end

    assign hall_sensor  = hall_sensor_r;
    assign hall_valid   = hall_valid_r;
    assign hall_fault   = hall_fault_r;
    assign dir          = dir_r;
    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign stall        = stall_r;

endmodule

// File: doc/hall_sensor_conditioner.md
# hall_sensor_conditioner

Conditions the three raw Hall-effect inputs before they drive the commutation logic: synchronises them to `clk`, rejects glitches, checks code legality and sequence, and measures electrical-sector period and rotation direction. Its `hall_sensor` output connects directly to the commutation controller's `hall_sensor` input. On any fault it forces code 3'b000, for which the commutation logic turns all six bridge transistors off.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per Hall bit (≥2).
- `FILTER_CYCLES`, 16: consecutive stable synchronised samples required to accept a new code (≥1).
- `PERIOD_W`, 24: width of period counter/output.
- `STALL_CYCLES`, 2**22: cycles without an accepted edge before `stall` asserts (≤ 2**PERIOD_W−1).

- `clk`, in, 1: system clock; the only clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `hall_raw`, in, 3: unsynchronised Hall inputs.
- `fault_clr`, in, 1: single-cycle pulse; leaves FAULT.
- `hall_sensor`, out, 3: filtered, validated code to the commutation stage.
- `hall_valid`, out, 1: `hall_sensor` holds a legal accepted code.
- `hall_fault`, out, 1: sticky fault flag.
- `dir`, out, 1: 1 = forward, 0 = reverse, as determined by the last accepted transition.
- `period`, out, PERIOD_W: cycles between the last two accepted edges.
- `period_valid`, out, 1: one-cycle pulse when `period` updates.
- `stall`, out, 1: no edge seen for STALL_CYCLES cycles.

## Operation
- Forward sequence: 101→100→110→010→011→001→101. Reverse is the opposite order. Codes 000 and 111 are illegal.
- Filter: `cand` is the synchronised code, `acc` is the accepted code.
  - The counter increments while the synchronised code equals `cand` and differs from `acc`.
  - It reloads to 1, with the new `cand`, whenever the synchronised code changes.
  - When it reaches FILTER_CYCLES, the code is accepted: `acc` updates and a one-cycle `edge` event fires.
- FSM has three states: INIT (reset state), RUN, FAULT.
  - **INIT:** an accepted legal code → RUN, with `hall_valid`=1. No direction or period is produced. An accepted illegal code → FAULT.
  - **RUN:** an accepted forward neighbour sets `dir`=1; an accepted reverse neighbour sets `dir`=0. An accepted illegal or non-adjacent code → FAULT.
  - **FAULT:** `hall_sensor`=000, `hall_valid`=0, `hall_fault`=1. `fault_clr` → INIT: `acc` reloads to 000, the filter restarts, and the period counter clears.
- `fault_clr` is ignored outside FAULT. If `fault_clr` and a fault-causing acceptance occur in the same cycle, the fault wins.
- Period counter (RUN only):
  - It increments every cycle and holds at STALL_CYCLES.
  - On a RUN edge with `stall`=0: `period` ← counter+1, `period_valid` pulses, and the counter clears.
  - The first edge after INIT→RUN does not pulse `period_valid`.
  - When the counter reaches STALL_CYCLES, `stall`=1. The next edge clears `stall` and the counter but does not pulse `period_valid`.
- `period` holds its value between updates. It is not cleared on fault.

## Timing
- Reset values:
  - `hall_sensor`=000, `hall_valid`=0, `hall_fault`=0, `dir`=0.
  - `period`=all ones, `period_valid`=0, `stall`=1.
  - Synchronisers, filter counter, `cand` and `acc` all reset to 0.
- Latency: a raw change stable from sampling edge k appears on `hall_sensor` after edge k+SYNC_STAGES+FILTER_CYCLES−1.
- The following all update on that same edge: `dir`, `hall_valid`, the FAULT entry and `hall_fault`, and `period`/`period_valid`.
- Every output is registered; there are no combinational paths from input to output.
- If `rst_n` is asserted mid-operation, all state returns to reset values immediately. Release is synchronised internally (two-flop release).
- A pulse shorter than FILTER_CYCLES synchronised cycles never reaches `hall_sensor`.

## Structure
- Package `hall_pkg` holds:
  - constants for the six legal codes;
  - the FSM state enum;
  - functions `hall_next(code)` and `hall_prev(code)`, which return the forward and reverse neighbour (000 for illegal codes).
- Sub-module `hall_glitch_filter` contains the synchroniser, `cand`/`acc`, the counter, and the `edge` and `acc` outputs. The top level holds the FSM and the period/stall logic.

## Test plan
Bench parameters: SYNC_STAGES=2, FILTER_CYCLES=4, STALL_CYCLES=1000.
- **Forward rotation:** after reset, drive `hall_raw`=101, then 100, 110, 010 every 200 cycles → `hall_sensor` follows each code 5 cycles after the change, `dir`=1, `period`=200 with `period_valid` pulsing on the 3rd and 4th codes only, `stall` clears on the first RUN edge.
- **Glitch rejection:** while in RUN at 100, drive 110 for 3 cycles, then 100 → `hall_sensor` stays 100, no `period_valid`.
- **Illegal code:** in RUN, drive 111 for 10 cycles → `hall_sensor`=000, `hall_valid`=0, `hall_fault`=1. `fault_clr` with `hall_raw`=011 → INIT, then `hall_sensor`=011 and `hall_valid`=1 after 4 further cycles.
- **Sequence jump:** in RUN at 101, drive 110 → FAULT. Asserting `fault_clr` in the same cycle as the acceptance leaves FAULT held.
- **Reverse rotation and stall:** drive 001→011 → `dir`=0. Hold for 1000 cycles → `stall`=1. The next edge clears `stall` without `period_valid`.
- **Reset:** assert `rst_n`=0 mid-rotation → all outputs immediately at reset values.
